// File: rtl/arb_2to1_32bit_pkg.sv
// Shared types, widths and the tie-break rule for the two-requester round-robin arbiter.
package arb_2to1_32bit_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } arb_state_t;

  // Winner among the valid requesters; the pointer only matters on a tie.
  function automatic logic next_grant(input logic pointer, input logic v0, input logic v1);
    logic sel;
    if (v0 && v1) begin
      sel = pointer;
    end else if (v1) begin
      sel = 1'b1;
    end else begin
      sel = 1'b0;
    end
    return sel;
  endfunction

  function automatic arb_state_t grant_state(input logic sel);
    return sel ? GRANT1 : GRANT0;
  endfunction

endpackage

// File: rtl/arb_2to1_32bit_if.sv
// Handshake bundle between two requesters, the arbiter and the single downstream consumer.
interface arb_2to1_32bit_if;
  import arb_2to1_32bit_pkg::*;

  logic              in0_valid;
  logic [DATA_W-1:0] in0_data;
  logic              in0_last;
  logic              in0_ready;
  logic              in1_valid;
  logic [DATA_W-1:0] in1_data;
  logic              in1_last;
  logic              in1_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              out_last;
  logic              out_ready;

  modport slave (
    input  in0_valid, in0_data, in0_last,
    output in0_ready,
    input  in1_valid, in1_data, in1_last,
    output in1_ready,
    output out_valid, out_data, out_src, out_last,
    input  out_ready
  );

  modport master (
    output in0_valid, in0_data, in0_last,
    input  in0_ready,
    output in1_valid, in1_data, in1_last,
    input  in1_ready,
    input  out_valid, out_data, out_src, out_last,
    output out_ready
  );

endinterface

// File: rtl/arb_2to1_32bit_mux.sv
// Data-path selector: routes the granted requester's beat towards the output register.
module mux_2to1_32bit #(
  parameter int W = 32
) (
  input  logic         i_sel,
  input  logic [W-1:0] i_d0,
  input  logic [W-1:0] i_d1,
  output logic [W-1:0] o_d
);

  assign o_d = (i_sel == 1'b1) ? i_d1 : i_d0;

endmodule

// File: rtl/arb_2to1_32bit.sv
// Round-robin 2:1 arbiter with burst hold, burst cap and a registered output beat.
module arb_2to1_32bit
  import arb_2to1_32bit_pkg::*;
#(
  parameter logic RESET_PRIO = 1'b0,
  parameter int   MAX_BURST  = 16
) (
  input logic               clk,
  input logic               rst,
  arb_2to1_32bit_if.slave   bus
);

  localparam int               CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_t        r_state, w_state_nxt;
  logic              r_ptr, w_ptr_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
  logic              r_out_valid, r_out_src, r_out_last;
  logic [DATA_W-1:0] r_out_data, w_mux_data;
  logic              w_gnt_valid, w_gnt, w_room;
  logic              w_rdy0, w_rdy1, w_accept, w_acc_last, w_release;

  mux_2to1_32bit #(.W(DATA_W)) u_data_mux (
    .i_sel (w_gnt),
    .i_d0  (bus.in0_data),
    .i_d1  (bus.in1_data),
    .o_d   (w_mux_data)
  );

  // Grant decode, handshakes and next FSM/pointer/count values
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = 1'b0;
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        w_gnt_valid = bus.in0_valid || bus.in1_valid;
        w_gnt       = next_grant(r_ptr, bus.in0_valid, bus.in1_valid);
      end
      GRANT0: begin
        w_gnt_valid = 1'b1;
        w_gnt       = 1'b0;
      end
      GRANT1: begin
        w_gnt_valid = 1'b1;
        w_gnt       = 1'b1;
      end
      default: begin
        w_gnt_valid = 1'b0;
        w_gnt       = 1'b0;
      end
    endcase
    w_room     = !r_out_valid || bus.out_ready;
    w_rdy0     = !rst && w_gnt_valid && !w_gnt && bus.in0_valid && w_room;
    w_rdy1     = !rst && w_gnt_valid &&  w_gnt && bus.in1_valid && w_room;
    w_accept   = w_rdy0 || w_rdy1;
    w_acc_last = w_gnt ? bus.in1_last : bus.in0_last;
    w_cnt_inc  = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
    w_release  = w_accept && (w_acc_last || (w_cnt_inc == CNT_MAX));
    // On release the other side gets the tie, and the new owner is chosen this cycle
    if (w_release) begin
      w_ptr_nxt = !w_gnt;
      w_cnt_nxt = '0;
      if (bus.in0_valid || bus.in1_valid) begin
        w_state_nxt = grant_state(next_grant(!w_gnt, bus.in0_valid, bus.in1_valid));
      end else begin
        w_state_nxt = IDLE;
      end
    end else if (w_gnt_valid) begin
      w_state_nxt = grant_state(w_gnt);
      if (w_accept) begin
        w_cnt_nxt = w_cnt_inc;
      end else begin
        w_cnt_nxt = r_cnt;
      end
    end else begin
      w_state_nxt = IDLE;
    end
  end

  // FSM state, round-robin pointer and burst beat counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= RESET_PRIO;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output beat register: load on accept, hold under backpressure, clear after drain
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_src   <= 1'b0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_mux_data;
      r_out_src   <= w_gnt;
      r_out_last  <= w_acc_last;
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in0_ready = w_rdy0;
  assign bus.in1_ready = w_rdy1;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_src   = r_out_src;
  assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_arb_2to1_32bit.sv
// Scoreboard bench for arb_2to1_32bit: directed scenarios then randomized traffic.
module tb_arb_2to1_32bit;
  import arb_2to1_32bit_pkg::*;

  localparam int   MAXB = 4;
  localparam logic PRIO = 1'b0;

  logic clk = 1'b0;
  logic rst;
  arb_2to1_32bit_if bus ();

  arb_2to1_32bit #(.RESET_PRIO(PRIO), .MAX_BURST(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] data; logic last; } beat_t;
  typedef struct packed { logic src; logic last; logic [31:0] data; } exp_t;

  beat_t src_q0[$];
  beat_t src_q1[$];
  exp_t  sb[$];
  int    n_cmp = 0;
  int    n_err = 0;

  // reference model: who owns the channel, tie pointer, beats in current grant, output slot
  int    m_owner = -1;
  logic  m_ptr   = PRIO;
  int    m_cnt   = 0;
  logic  m_full  = 1'b0;

  logic  acc0 = 1'b0, acc1 = 1'b0;
  int    acc_cnt0 = 0;
  bit    gen_on = 1'b0;
  bit    force_stall = 1'b0;
  int    valid_pct = 100;
  int    ready_pct = 100;
  logic  stall_prev = 1'b0;
  logic [33:0] stall_val;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int pick(input logic ptr, input logic v0, input logic v1);
    if (v0 && v1) return ptr ? 1 : 0;
    return v1 ? 1 : 0;
  endfunction

  // model: expected readys, push expected beats, advance ownership
  always @(negedge clk) begin
    int own;
    logic v0, v1, room, e0, e1, s, l;
    v0 = bus.in0_valid;
    v1 = bus.in1_valid;
    own = m_owner;
    room = 1'b0;
    if (rst) begin
      e0 = 1'b0;
      e1 = 1'b0;
    end else begin
      if (own < 0 && (v0 || v1)) own = pick(m_ptr, v0, v1);
      room = !m_full || bus.out_ready;
      e0 = (own == 0) && v0 && room;
      e1 = (own == 1) && v1 && room;
    end
    check("in0_ready", 64'(bus.in0_ready), 64'(e0));
    check("in1_ready", 64'(bus.in1_ready), 64'(e1));
    check("out_valid", 64'(bus.out_valid), 64'(m_full));
    acc0 = v0 && bus.in0_ready;
    acc1 = v1 && bus.in1_ready;
    if (rst) begin
      m_owner = -1;
      m_ptr   = PRIO;
      m_cnt   = 0;
      m_full  = 1'b0;
      sb.delete();
    end else begin
      m_full = e0 || e1 || (m_full && !bus.out_ready);
      m_owner = own;
      if (e0 || e1) begin
        s = e1;
        l = s ? bus.in1_last : bus.in0_last;
        sb.push_back({s, l, s ? bus.in1_data : bus.in0_data});
        m_cnt++;
        if (l || m_cnt == MAXB) begin
          m_ptr   = !s;
          m_cnt   = 0;
          m_owner = (v0 || v1) ? pick(m_ptr, v0, v1) : -1;
        end
      end
    end
  end

  // monitor: compare each transferred beat and check stability while stalled
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(bus.out_valid), 64'(1'b1));
        check("stall_beat", 64'({bus.out_src, bus.out_last, bus.out_data}), 64'(stall_val));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_beat: got unexpected beat %h src %0d, expected none", bus.out_data, bus.out_src);
        end else begin
          e = sb.pop_front();
          check("out_beat", 64'({bus.out_src, bus.out_last, bus.out_data}), 64'(e));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      stall_val  = {bus.out_src, bus.out_last, bus.out_data};
    end
  end

  task automatic push_burst(input int side, input int len, input logic [31:0] d, input bit rnd);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? 32'($urandom) : d + 32'(i);
      b.last = (i == len - 1);
      if (side == 0) src_q0.push_back(b);
      else src_q1.push_back(b);
    end
  endtask

  task automatic drive(input logic h0, input logic h1);
    bus.in0_valid = (src_q0.size() > 0) && (h0 || ($urandom % 100) < valid_pct);
    bus.in1_valid = (src_q1.size() > 0) && (h1 || ($urandom % 100) < valid_pct);
    bus.in0_data  = (src_q0.size() > 0) ? src_q0[0].data : 32'h0;
    bus.in0_last  = (src_q0.size() > 0) ? src_q0[0].last : 1'b0;
    bus.in1_data  = (src_q1.size() > 0) ? src_q1[0].data : 32'h0;
    bus.in1_last  = (src_q1.size() > 0) ? src_q1[0].last : 1'b0;
    bus.out_ready = force_stall ? 1'b0 : (($urandom % 100) < ready_pct);
  endtask

  task automatic step();
    logic h0, h1;
    @(posedge clk);
    #1;
    h0 = bus.in0_valid && !acc0;
    h1 = bus.in1_valid && !acc1;
    if (acc0) begin
      void'(src_q0.pop_front());
      acc_cnt0++;
    end
    if (acc1) void'(src_q1.pop_front());
    if (gen_on) begin
      if (src_q0.size() == 0 && $urandom_range(0, 7) == 0) push_burst(0, $urandom_range(1, 10), 32'h0, 1'b1);
      if (src_q1.size() == 0 && $urandom_range(0, 7) == 0) push_burst(1, $urandom_range(1, 10), 32'h0, 1'b1);
    end
    drive(h0, h1);
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    src_q0.delete();
    src_q1.delete();
    drive(1'b0, 1'b0);
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  task automatic drain(input string name, input int budget);
    int k;
    k = 0;
    while ((src_q0.size() != 0 || src_q1.size() != 0 || sb.size() != 0 || bus.out_valid) && k < budget) begin
      step();
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_err++;
      $display("FAIL drain_%s: got %0d beats still pending after %0d cycles, expected 0",
               name, src_q0.size() + src_q1.size() + sb.size(), budget);
    end
  endtask

  initial begin
    // reset held two cycles with both requesters presenting beats
    rst = 1'b1;
    push_burst(0, 1, 32'h1111_0000, 1'b0);
    push_burst(1, 1, 32'h2222_0000, 1'b0);
    drive(1'b0, 1'b0);
    step();
    step();
    check("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    check("rst_out_data", 64'(bus.out_data), 64'(32'h0));
    check("rst_out_src", 64'(bus.out_src), 64'(1'b0));
    rst = 1'b0;
    src_q0.delete();
    src_q1.delete();

    // tie: single-beat bursts from both sides alternate
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      push_burst(0, 1, 32'hAAAA_0000, 1'b0);
      push_burst(1, 1, 32'h5555_0001, 1'b0);
    end
    drive(1'b0, 1'b0);
    drain("tie", 100);

    // burst of 4 held against a constantly valid competitor
    do_reset(1);
    push_burst(0, 4, 32'hB000_0000, 1'b0);
    push_burst(1, 1, 32'hC000_0000, 1'b0);
    push_burst(1, 1, 32'hC000_0001, 1'b0);
    drive(1'b0, 1'b0);
    drain("burst", 100);

    // 10-beat burst split by the cap of 4
    do_reset(1);
    push_burst(0, 10, 32'hD000_0000, 1'b0);
    for (int i = 0; i < 3; i++) push_burst(1, 1, 32'hE000_0000 + 32'(i), 1'b0);
    drive(1'b0, 1'b0);
    drain("cap", 100);

    // backpressure: consumer stalls 3 cycles mid-stream
    do_reset(1);
    push_burst(0, 6, 32'hF000_0000, 1'b0);
    push_burst(1, 6, 32'hF100_0000, 1'b0);
    drive(1'b0, 1'b0);
    repeat (3) step();
    force_stall = 1'b1;
    repeat (3) step();
    force_stall = 1'b0;
    drain("backpressure", 100);

    // reset after beat 2 of a 4-beat burst
    do_reset(1);
    acc_cnt0 = 0;
    push_burst(0, 4, 32'h7000_0000, 1'b0);
    drive(1'b0, 1'b0);
    for (int k = 0; k < 20 && acc_cnt0 < 2; k++) step();
    check("midburst_beats", 64'(acc_cnt0), 64'(2));
    rst = 1'b1;
    src_q0.delete();
    src_q1.delete();
    step();
    rst = 1'b0;
    check("midrst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    check("midrst_state", 64'(dut.r_state), 64'(IDLE));
    check("midrst_ptr", 64'(dut.r_ptr), 64'(PRIO));
    push_burst(0, 1, 32'h7100_0000, 1'b0);
    push_burst(1, 1, 32'h7200_0000, 1'b0);
    drive(1'b0, 1'b0);
    drain("after_reset", 50);

    // randomized traffic with a forced stall
    do_reset(1);
    gen_on    = 1'b1;
    valid_pct = 75;
    ready_pct = 70;
    for (int c = 0; c < 1500; c++) begin
      force_stall = (c >= 500 && c < 503);
      step();
    end
    force_stall = 1'b0;
    gen_on = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
